ram_arbiter: RTL and testbench

Two-master arbiter and sequencer for the shared SRAM driver, which has a single command port. Two requesters, master 0 (instruction fetch) and master 1 (data port / memory loader), each issue word read or write requests. The arbiter grants one at a time with round-robin fairness, drives the driver's enable/read/write strobes, and waits for completion. It returns read data with a one-cycle acknowledge and aborts hung accesses with a timeout.

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/ram_arbiter_rr_pick2.sv | 24 ++
 rtl/ram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ram_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master SRAM arbiter: sequencer states and
// master index constants.
package ram_arbiter_pkg;

   // Sequencer states: sample requests, latch command, strobe the driver, acknowledge.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Master indices as seen on the owner output and in grant decisions.
   localparam logic M_IFETCH = 1'b0;
   localparam logic M_DATA   = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins outright, and on a tie
// the master that did not hold the last grant wins.
module rr_pick2
   import ram_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant_valid,
   output logic grant_idx
);

   // Pick a winner from the current requests and the previous owner.
   always_comb begin
      grant_valid = req0 | req1;
      grant_idx   = M_IFETCH;
      if (req0 && req1) begin
         grant_idx = ~last;
      end else if (req1) begin
         grant_idx = M_DATA;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter and sequencer sharing one SRAM driver command port between the
// instruction-fetch master and the data master, with completion timeout.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH     = 21,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic                  err0,
   output logic                  err1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_en,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_read_ready,
   input  logic                  mem_write_done,
   output logic                  busy,
   output logic                  owner,
   output logic                  timeout_flag
);

   // Counter only needs to reach TIMEOUT_CYCLES-1 since the compare precedes the increment.
   localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                state_q, state_d;
   logic                  sel_q, sel_d;
   logic                  owner_q, owner_d;
   logic                  cmd_we_q, cmd_we_d;
   logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic                  err0_q, err0_d;
   logic                  err1_q, err1_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic                  busy_q, busy_d;
   logic                  tflag_q, tflag_d;
   logic                  grant_valid;
   logic                  grant_idx;
   logic                  done;

   rr_pick2 u_pick (
      .req0        (req0),
      .req1        (req1),
      .last        (owner_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Next-state, command latch, timeout and registered-output decode.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      owner_d     = owner_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      tflag_d     = tflag_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      err0_d      = 1'b0;
      err1_d      = 1'b0;
      done        = cmd_we_q ? mem_write_done : mem_read_ready;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               sel_d   = grant_idx;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            owner_d     = sel_q;
            cmd_we_d    = (sel_q == M_DATA) ? we1    : we0;
            cmd_addr_d  = (sel_q == M_DATA) ? addr1  : addr0;
            cmd_wdata_d = (sel_q == M_DATA) ? wdata1 : wdata0;
            cnt_d       = '0;
            state_d     = WAIT;
         end
         WAIT: begin
            if (done) begin
               if (!cmd_we_q) begin
                  rdata_d = mem_rdata;
               end
               ack0_d  = (owner_q == M_IFETCH);
               ack1_d  = (owner_q == M_DATA);
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               ack0_d  = (owner_q == M_IFETCH);
               ack1_d  = (owner_q == M_DATA);
               err0_d  = (owner_q == M_IFETCH);
               err1_d  = (owner_q == M_DATA);
               tflag_d = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      mem_en_d    = (state_d == WAIT);
      mem_read_d  = mem_en_d & ~cmd_we_d;
      mem_write_d = mem_en_d & cmd_we_d;
      busy_d      = (state_d != IDLE);
   end

   // State and output registers; reset drops strobes immediately and cancels any ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= M_IFETCH;
         owner_q     <= M_DATA;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cnt_q       <= '0;
         rdata_q     <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         busy_q      <= 1'b0;
         tflag_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         owner_q     <= owner_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         err0_q      <= err0_d;
         err1_q      <= err1_d;
         mem_en_q    <= mem_en_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         busy_q      <= busy_d;
         tflag_q     <= tflag_d;
      end
   end

   assign ack0         = ack0_q;
   assign ack1         = ack1_q;
   assign err0         = err0_q;
   assign err1         = err1_q;
   assign rdata        = rdata_q;
   assign mem_en       = mem_en_q;
   assign mem_read     = mem_read_q;
   assign mem_write    = mem_write_q;
   assign mem_addr     = cmd_addr_q;
   assign mem_wdata    = cmd_wdata_q;
   assign busy         = busy_q;
   assign owner        = owner_q;
   assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: expected acknowledges are queued at issue
// time and a monitor compares them against every ack the arbiter produces.
module tb_ram_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [20:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        ack0, ack1, err0, err1;
   logic [31:0] rdata;
   logic        mem_en, mem_read, mem_write;
   logic [20:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_read_ready, mem_write_done;
   logic        busy, owner, timeout_flag;

   typedef struct {
      logic        m;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   drv_delay = 0;
   logic [31:0] drv_rdata = '0;
   int   wait_cnt = 0;
   int   wait_len = 0;

   ram_arbiter #(
      .ADDR_WIDTH     (21),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req0           (req0),
      .req1           (req1),
      .we0            (we0),
      .we1            (we1),
      .addr0          (addr0),
      .addr1          (addr1),
      .wdata0         (wdata0),
      .wdata1         (wdata1),
      .ack0           (ack0),
      .ack1           (ack1),
      .err0           (err0),
      .err1           (err1),
      .rdata          (rdata),
      .mem_en         (mem_en),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_read_ready (mem_read_ready),
      .mem_write_done (mem_write_done),
      .busy           (busy),
      .owner          (owner),
      .timeout_flag   (timeout_flag)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = drv_rdata;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Queue the expected response, then raise the request for one master.
   task automatic applyStimulus(input logic m, input logic we, input logic [20:0] addr,
                                input logic [31:0] wdata, input logic exp_err,
                                input logic [31:0] exp_rdata);
      exp_t e;
      e.m = m; e.err = exp_err; e.rdata = exp_rdata;
      exp_q.push_back(e);
      if (m) begin
         we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
      end else begin
         we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
      end
   endtask

   task automatic waitStrobe();
      int n = 0;
      while (!mem_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!mem_en) checkOutput("strobe_wait", {31'b0, mem_en}, 32'd1);
   endtask

   task automatic waitDone();
      int n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || busy) begin
         checkOutput("done_wait", exp_q.size(), 32'd0);
         exp_q.delete();
      end
   endtask

   // Driver model: raise the completion flag in the drv_delay-th strobed cycle, track WAIT length.
   always @(negedge clk) begin
      if (mem_en) begin
         wait_cnt = wait_cnt + 1;
         mem_read_ready = (wait_cnt == drv_delay) && mem_read;
         mem_write_done = (wait_cnt == drv_delay) && mem_write;
      end else begin
         if (wait_cnt != 0) wait_len = wait_cnt;
         wait_cnt = 0;
         mem_read_ready = 1'b0;
         mem_write_done = 1'b0;
      end
   end

   // Requesters drop req as soon as their ack is seen.
   always @(negedge clk) begin
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
   end

   // Monitor: every ack pops one expected response and is compared against it.
   always @(negedge clk) begin
      if (!rst && (ack0 || ack1)) begin
         exp_t e;
         checkOutput("dual_ack", {31'b0, ack0 & ack1}, 32'd0);
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_ack", {30'b0, ack1, ack0}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("ack_master", {31'b0, ack1}, {31'b0, e.m});
            checkOutput("ack_err", {31'b0, (e.m ? err1 : err0)}, {31'b0, e.err});
            checkOutput("other_err", {31'b0, (e.m ? err0 : err1)}, 32'd0);
            checkOutput("ack_rdata", rdata, e.rdata);
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      mem_read_ready = 0; mem_write_done = 0;
      repeat (3) @(negedge clk);

      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_owner", {31'b0, owner}, 32'd1);
      checkOutput("rst_ack", {30'b0, ack1, ack0}, 32'd0);
      checkOutput("rst_strobes", {29'b0, mem_en, mem_read, mem_write}, 32'd0);
      checkOutput("rst_tflag", {31'b0, timeout_flag}, 32'd0);
      checkOutput("rst_rdata", rdata, 32'd0);
      checkOutput("rst_mem_addr", {11'b0, mem_addr}, 32'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] single read");
      drv_delay = 3; drv_rdata = 32'hDEADBEEF;
      applyStimulus(1'b0, 1'b0, 21'h00123, 32'h0, 1'b0, 32'hDEADBEEF);
      waitStrobe();
      checkOutput("rd_mem_addr", {11'b0, mem_addr}, 32'h00123);
      checkOutput("rd_strobes", {29'b0, mem_en, mem_read, mem_write}, 32'b110);
      waitDone();
      checkOutput("rd_owner", {31'b0, owner}, 32'd0);

      $display("[TB] single write");
      drv_delay = 1;
      applyStimulus(1'b1, 1'b1, 21'h1FFFF, 32'h0000A5A5, 1'b0, 32'hDEADBEEF);
      waitStrobe();
      checkOutput("wr_strobes", {29'b0, mem_en, mem_read, mem_write}, 32'b101);
      checkOutput("wr_mem_wdata", mem_wdata, 32'h0000A5A5);
      checkOutput("wr_mem_addr", {11'b0, mem_addr}, 32'h1FFFF);
      waitDone();
      checkOutput("wr_owner", {31'b0, owner}, 32'd1);

      $display("[TB] contention from reset");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drv_delay = 1; drv_rdata = 32'hCAFE0001;
      applyStimulus(1'b0, 1'b0, 21'h00010, 32'h0, 1'b0, 32'hCAFE0001);
      applyStimulus(1'b1, 1'b1, 21'h00042, 32'h11112222, 1'b0, 32'hCAFE0001);
      n = 0;
      while (!ack0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ack0) checkOutput("ack0_wait", {31'b0, ack0}, 32'd1);
      @(negedge clk);
      drv_rdata = 32'hCAFE0002;
      applyStimulus(1'b0, 1'b0, 21'h00011, 32'h0, 1'b0, 32'hCAFE0002);
      waitDone();

      $display("[TB] completion on last wait cycle");
      drv_delay = 8; drv_rdata = 32'h12345678;
      applyStimulus(1'b1, 1'b0, 21'h00077, 32'h0, 1'b0, 32'h12345678);
      waitDone();
      checkOutput("last_wait_len", wait_len, 32'd8);
      checkOutput("last_tflag", {31'b0, timeout_flag}, 32'd0);

      $display("[TB] timeout");
      drv_delay = 0; drv_rdata = 32'hFFFFFFFF;
      applyStimulus(1'b0, 1'b0, 21'h00ABC, 32'h0, 1'b1, 32'h0);
      waitDone();
      checkOutput("to_wait_len", wait_len, 32'd8);
      checkOutput("to_tflag", {31'b0, timeout_flag}, 32'd1);

      $display("[TB] access after timeout");
      drv_delay = 2; drv_rdata = 32'h0BADF00D;
      applyStimulus(1'b0, 1'b0, 21'h00001, 32'h0, 1'b0, 32'h0BADF00D);
      waitDone();
      checkOutput("post_tflag", {31'b0, timeout_flag}, 32'd1);

      $display("[TB] reset mid-wait");
      drv_delay = 0;
      we0 = 1'b0; addr0 = 21'h00200; req0 = 1'b1;
      waitStrobe();
      @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      req0 = 1'b0;
      #1;
      checkOutput("mid_rst_strobes", {29'b0, mem_en, mem_read, mem_write}, 32'd0);
      checkOutput("mid_rst_ack", {30'b0, ack1, ack0}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("post_rst_owner", {31'b0, owner}, 32'd1);
      checkOutput("post_rst_tflag", {31'b0, timeout_flag}, 32'd0);
      checkOutput("post_rst_queue", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
